mux_arb_reg: RTL and testbench
==============================

Name: mux_arb_reg

Overview:
- Parametrised successor to the fixed 3x16 operand mux: N_CH input channels of DW bits, each with a valid/ready handshake, into one registered output with a valid/ready handshake.
- Two modes: MODE=0 selects by sel_in; MODE=1 arbitrates round-robin among valid channels.
- Sits between producer units (ALU, load path, immediate path) and a shared consumer such as the register-file write port. It adds one pipeline register stage and back-pressure.

Parameters:
- N_CH, 3, number of input channels; legal range 2..16.
- DW, 16, data width in bits.
- MODE, 0, arbitration mode: 0 = sel_in-driven, 1 = round-robin.
- SW, $clog2(N_CH) (min 1), select width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- sel_in  input  SW  channel select; used only when MODE=0.
- valid_in  input  N_CH  per-channel valid; bit k belongs to channel k.
- d_in  input  N_CH*DW  packed channel data; channel k occupies bits [k*DW +: DW].
- ready_out  output  N_CH  per-channel ready (grant); at most one bit is high.
- m_out  output  DW  registered output data.
- m_valid_out  output  1  output register holds valid data.
- m_ready_in  input  1  consumer accepts m_out.
- grant_id_out  output  SW  index of the channel that produced the current m_out.

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - m_out = '0, m_valid_out = 0, grant_id_out = '0.
  - Round-robin pointer rr_ptr = 0.
  - ready_out is all zeros while reset is asserted.
- Reset mid-transfer drops the held word; there is no recovery.
- load_en = !m_valid_out || m_ready_in. The output register accepts a new word only when load_en=1.
- Channel selection when MODE=0:
  - g = sel_in.
  - If sel_in >= N_CH, no channel is granted: ready_out = 0 and no load. This is the successor of the old "out-of-range select gives 0" rule.
- Channel selection when MODE=1:
  - g = first k with valid_in[k]=1, scanning rr_ptr, rr_ptr+1, ..., N_CH-1, 0, ..., rr_ptr-1 (wrap-around).
  - If no channel is valid, there is no grant.
- ready_out[g] = load_en, and it is combinational from valid_in, sel_in, rr_ptr, m_valid_out and m_ready_in.
  - In MODE=0, ready_out[g] is asserted even if valid_in[g]=0.
  - In MODE=1, ready_out is asserted only toward a valid channel.
- Input transfer on a rising edge when valid_in[g] && ready_out[g]:
  - m_out <= d_in[g]
  - grant_id_out <= g
  - m_valid_out <= 1
  - In MODE=1 only: rr_ptr <= (g == N_CH-1) ? 0 : g+1.
- Output transfer when m_valid_out && m_ready_in:
  - If there is no simultaneous input transfer, m_valid_out <= 0. m_out and grant_id_out hold their last value.
  - If there is a simultaneous input transfer, the register reloads and m_valid_out stays 1. Full throughput is one word per cycle.
- Stall (m_valid_out=1, m_ready_in=0):
  - ready_out = 0.
  - m_out, grant_id_out and rr_ptr are stable.
  - Producers must hold valid_in and d_in.
- rr_ptr does not move in cycles without a transfer.
- Latency: one cycle from input transfer to m_valid_out=1. There is no combinational path from d_in to m_out.
- Data is passed unmodified; no width conversion is performed.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with m_valid_out=1 -> m_out=0000, m_valid_out=0 and ready_out=000 immediately (asynchronous); first grant after release, in MODE=1 with all valid, is channel 0.
- MODE=0, N_CH=3, DW=16: sel_in=1, valid_in=010, d_in ch1=A5A5, m_ready_in=1 -> next cycle m_out=A5A5, m_valid_out=1, grant_id_out=1; then sel_in=3 -> ready_out=000 and m_valid_out falls to 0 after the output drains.
- MODE=1, N_CH=4, all valid_in=1111, m_ready_in=1 held, d_in ch k = 1000+k -> m_out sequence 1000, 1001, 1002, 1003, 1000 on consecutive cycles, showing wrap-around.
- MODE=1, valid_in=1010 with rr_ptr=2 -> grant ch3 and rr_ptr becomes 0; next grant ch1.
- Back-pressure: m_ready_in=0 for 3 cycles with a word held -> ready_out=0000 and m_out stable for all 3 cycles; on release, a new word loads in the same cycle the old word drains, so there is no bubble.
- Simultaneous events, MODE=0: N_CH=2, m_valid_out=1, m_ready_in=1, valid_in[sel]=1 -> m_valid_out stays 1 and m_out updates; N_CH=16, SW=4, sel_in=15 -> ch15 data passes.

Source files
------------

// File: rtl/mux_arb_reg.sv
// -----------------------------------------------------------------------------
// mux_arb_reg
//
// N_CH-input, one-output operand multiplexer with a registered output stage and
// valid/ready back-pressure on both sides. It sits between producer units (ALU,
// load path, immediate path) and a shared consumer such as a register-file
// write port.
//
// Channel choice:
//   MODE = 0 : the channel is picked directly by sel_in. A select at or beyond
//              N_CH grants nothing and never loads.
//   MODE = 1 : round-robin among the valid channels. The scan starts at rr_ptr
//              and wraps. After a transfer from channel g, rr_ptr moves to the
//              channel after g.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous, active-low reset
//   sel_in        channel select (MODE = 0 only)
//   valid_in      per-channel valid, bit k belongs to channel k
//   d_in          packed channel data, channel k at [k*DW +: DW]
//   ready_out     per-channel grant, one-hot or zero
//   m_out         registered output data
//   m_valid_out   output register holds a word
//   m_ready_in    consumer accepts m_out this cycle
//   grant_id_out  channel index that produced the current m_out
// -----------------------------------------------------------------------------
module mux_arb_reg #(
    parameter int N_CH = 3,
    parameter int DW   = 16,
    parameter int MODE = 0,
    localparam int SW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SW-1:0]        sel_in,
    input  logic [N_CH-1:0]      valid_in,
    input  logic [N_CH*DW-1:0]   d_in,
    output logic [N_CH-1:0]      ready_out,
    output logic [DW-1:0]        m_out,
    output logic                 m_valid_out,
    input  logic                 m_ready_in,
    output logic [SW-1:0]        grant_id_out
);

    // The extra bit lets N_CH itself be represented when N_CH == 2**SW.
    localparam logic [SW:0]   NCH_W   = (SW+1)'(N_CH);
    localparam logic [SW-1:0] LAST_CH = SW'(N_CH - 1);

    // Next round-robin start point after a grant to channel g.
    function automatic logic [SW-1:0] rr_next(input logic [SW-1:0] g);
        return (g == LAST_CH) ? '0 : g + 1'b1;
    endfunction

    // (base + ofs) mod N_CH, for base < N_CH and ofs < N_CH.
    // The sum stays below 2*N_CH, so one conditional subtract is enough.
    function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] base,
                                               input int            ofs);
        logic [SW:0] sum;
        sum = {1'b0, base} + (SW+1)'(ofs);
        if (sum >= NCH_W) begin
            sum = sum - NCH_W;
        end
        return sum[SW-1:0];
    endfunction

    logic [DW-1:0]   ch_data [N_CH];
    logic [SW-1:0]   rr_ptr;
    logic [SW-1:0]   grant;
    logic            grant_vld;
    logic [SW-1:0]   scan_idx;
    logic [DW-1:0]   grant_data;
    logic            load_en;
    logic            xfer;

    logic [DW-1:0]   data_p1;
    logic [SW-1:0]   gid_p1;
    logic            vld_p1;

    for (genvar k = 0; k < N_CH; k++) begin : g_unpack
        assign ch_data[k] = d_in[k*DW +: DW];
    end

    // ---- stage 0: channel choice and input handshake (combinational) ----

    // The register can take a word when it is empty or being drained now.
    assign load_en = !vld_p1 || m_ready_in;

    always_comb begin : grant_sel
        grant     = '0;
        grant_vld = 1'b0;
        scan_idx  = '0;
        if (MODE != 1) begin
            grant     = sel_in;
            grant_vld = ({1'b0, sel_in} < NCH_W);
        end else begin
            // Lowest offset from rr_ptr wins.
            for (int i = 0; i < N_CH; i++) begin
                scan_idx = wrap_idx(rr_ptr, i);
                if (!grant_vld && valid_in[scan_idx]) begin
                    grant_vld = 1'b1;
                    grant     = scan_idx;
                end
            end
        end
    end

    // An equality mux keeps an out-of-range select from reading past ch_data.
    always_comb begin : data_sel
        grant_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant == SW'(k)) begin
                grant_data = ch_data[k];
            end
        end
    end

    // In MODE 0 the granted channel sees ready even when it is not valid.
    // Ready is held low for as long as reset is asserted.
    always_comb begin : ready_gen
        ready_out = '0;
        if (rst_n && grant_vld && load_en) begin
            ready_out[grant] = 1'b1;
        end
    end

    assign xfer = grant_vld && load_en && valid_in[grant];

    // ---- stage 1: output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1 <= '0;
            gid_p1  <= '0;
            vld_p1  <= 1'b0;
        end else begin
            if (xfer) begin
                data_p1 <= grant_data;
                gid_p1  <= grant;
                vld_p1  <= 1'b1;
            end else if (m_ready_in) begin
                // Drained with nothing new behind it.
                // Data and id keep their last value.
                vld_p1 <= 1'b0;
            end
        end
    end

    if (MODE == 1) begin : g_rr
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rr_ptr <= '0;
            end else if (xfer) begin
                rr_ptr <= rr_next(grant);
            end
        end
    end else begin : g_no_rr
        assign rr_ptr = '0;
    end

    assign m_out        = data_p1;
    assign m_valid_out  = vld_p1;
    assign grant_id_out = gid_p1;

endmodule

// File: tb/tb_mux_arb_reg.sv
// -----------------------------------------------------------------------------
// tb_mux_arb_reg
//
// Bench for mux_arb_reg. It uses four instances:
//   u0 : MODE 0, N_CH = 3
//   u1 : MODE 1, N_CH = 4
//   u2 : MODE 0, N_CH = 2
//   u3 : MODE 0, N_CH = 16
// The instances are exercised one after another from a single directed
// sequence. Each step applies inputs and checks ready_out before the clock
// edge against the bench's own grant model. Words the model expects to be
// accepted go into a scoreboard queue. After the edge, m_out, m_valid_out and
// grant_id_out are compared with the queue head.
// -----------------------------------------------------------------------------
module tb_mux_arb_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // u0: MODE 0, N_CH 3
    logic [1:0]   sel0;
    logic [2:0]   vin0;
    logic [47:0]  din0;
    logic [2:0]   rdy0;
    logic [15:0]  mo0;
    logic         mv0;
    logic         mr0;
    logic [1:0]   gid0;

    // u1: MODE 1, N_CH 4
    logic [1:0]   sel1;
    logic [3:0]   vin1;
    logic [63:0]  din1;
    logic [3:0]   rdy1;
    logic [15:0]  mo1;
    logic         mv1;
    logic         mr1;
    logic [1:0]   gid1;

    // u2: MODE 0, N_CH 2
    logic [0:0]   sel2;
    logic [1:0]   vin2;
    logic [31:0]  din2;
    logic [1:0]   rdy2;
    logic [15:0]  mo2;
    logic         mv2;
    logic         mr2;
    logic [0:0]   gid2;

    // u3: MODE 0, N_CH 16
    logic [3:0]   sel3;
    logic [15:0]  vin3;
    logic [255:0] din3;
    logic [15:0]  rdy3;
    logic [15:0]  mo3;
    logic         mv3;
    logic         mr3;
    logic [3:0]   gid3;

    mux_arb_reg #(.N_CH(3), .DW(16), .MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .sel_in(sel0), .valid_in(vin0), .d_in(din0),
        .ready_out(rdy0), .m_out(mo0), .m_valid_out(mv0), .m_ready_in(mr0),
        .grant_id_out(gid0));

    mux_arb_reg #(.N_CH(4), .DW(16), .MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .sel_in(sel1), .valid_in(vin1), .d_in(din1),
        .ready_out(rdy1), .m_out(mo1), .m_valid_out(mv1), .m_ready_in(mr1),
        .grant_id_out(gid1));

    mux_arb_reg #(.N_CH(2), .DW(16), .MODE(0)) u2 (
        .clk(clk), .rst_n(rst_n), .sel_in(sel2), .valid_in(vin2), .d_in(din2),
        .ready_out(rdy2), .m_out(mo2), .m_valid_out(mv2), .m_ready_in(mr2),
        .grant_id_out(gid2));

    mux_arb_reg #(.N_CH(16), .DW(16), .MODE(0)) u3 (
        .clk(clk), .rst_n(rst_n), .sel_in(sel3), .valid_in(vin3), .d_in(din3),
        .ready_out(rdy3), .m_out(mo3), .m_valid_out(mv3), .m_ready_in(mr3),
        .grant_id_out(gid3));

    int checks = 0;
    int errors = 0;

    // Each scoreboard entry is {gid[19:16], data[15:0]}.
    logic [31:0] sbq[$];
    int          rrm;
    logic [15:0] last_d [4];
    logic [3:0]  last_g [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sbq.delete();
        rrm = 0;
        for (int i = 0; i < 4; i++) begin
            last_d[i] = '0;
            last_g[i] = '0;
        end
    endtask

    // One clock step for instance u.
    // It is entered just after a rising edge and returns 1 time unit after
    // the next rising edge.
    task automatic step(input int u);
        logic [15:0]  v;
        logic [15:0]  rdy;
        logic [3:0]   s;
        logic [255:0] d;
        logic         mr;
        logic         mode1;
        logic         gv;
        logic         ld;
        logic         xf;
        logic [15:0]  exp_rdy;
        logic [15:0]  mo;
        logic         mv;
        logic [3:0]   gid;
        int           n;
        int           g;
        int           k;

        @(negedge clk);
        v = '0; rdy = '0; s = '0; d = '0; mr = 1'b0; mode1 = 1'b0; n = 2;
        case (u)
            0: begin v = 16'(vin0); rdy = 16'(rdy0); s = 4'(sel0); d = 256'(din0); mr = mr0; n = 3; end
            1: begin v = 16'(vin1); rdy = 16'(rdy1); s = 4'(sel1); d = 256'(din1); mr = mr1; n = 4; mode1 = 1'b1; end
            2: begin v = 16'(vin2); rdy = 16'(rdy2); s = 4'(sel2); d = 256'(din2); mr = mr2; n = 2; end
            default: begin v = vin3; rdy = rdy3; s = sel3; d = din3; mr = mr3; n = 16; end
        endcase

        ld = (sbq.size() == 0) || mr;
        gv = 1'b0;
        g  = 0;
        if (mode1) begin
            for (int i = 0; i < n; i++) begin
                k = (rrm + i) % n;
                if (!gv && v[k]) begin
                    gv = 1'b1;
                    g  = k;
                end
            end
        end else begin
            g  = int'(s);
            gv = (g < n);
        end
        exp_rdy = (gv && ld) ? (16'(1) << g) : 16'h0;
        chk($sformatf("u%0d_ready_out", u), 32'(rdy), 32'(exp_rdy));
        xf = gv && ld && v[g];

        @(posedge clk);
        if (sbq.size() > 0 && mr) begin
            void'(sbq.pop_front());
        end
        if (xf) begin
            sbq.push_back({12'd0, 4'(g), d[g*16 +: 16]});
            if (mode1) begin
                rrm = (g == n - 1) ? 0 : g + 1;
            end
        end

        #1;
        case (u)
            0: begin mo = mo0; mv = mv0; gid = 4'(gid0); end
            1: begin mo = mo1; mv = mv1; gid = 4'(gid1); end
            2: begin mo = mo2; mv = mv2; gid = 4'(gid2); end
            default: begin mo = mo3; mv = mv3; gid = gid3; end
        endcase
        if (sbq.size() > 0) begin
            chk($sformatf("u%0d_m_valid_out", u), 32'(mv), 32'd1);
            chk($sformatf("u%0d_m_out", u), 32'(mo), 32'(sbq[0][15:0]));
            chk($sformatf("u%0d_grant_id_out", u), 32'(gid), 32'(sbq[0][19:16]));
            last_d[u] = sbq[0][15:0];
            last_g[u] = sbq[0][19:16];
        end else begin
            chk($sformatf("u%0d_m_valid_out", u), 32'(mv), 32'd0);
            chk($sformatf("u%0d_m_out_hold", u), 32'(mo), 32'(last_d[u]));
            chk($sformatf("u%0d_grant_id_hold", u), 32'(gid), 32'(last_g[u]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        sel0 = 2'd1; vin0 = '0; din0 = '0; mr0 = 1'b1;
        sel1 = '0;   vin1 = 4'b1111; din1 = '0; mr1 = 1'b1;
        sel2 = '0;   vin2 = '0; din2 = '0; mr2 = 1'b1;
        sel3 = '0;   vin3 = '0; din3 = '0; mr3 = 1'b1;
        model_reset();

        // Power-on reset: outputs cleared and no grants, even with requests pending.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_u0_m_out", 32'(mo0), 32'h0);
        chk("rst_u0_m_valid", 32'(mv0), 32'h0);
        chk("rst_u0_gid", 32'(gid0), 32'h0);
        chk("rst_u0_ready", 32'(rdy0), 32'h0);
        chk("rst_u1_ready", 32'(rdy1), 32'h0);
        vin1  = '0;
        rst_n = 1'b1;

        // MODE 0 select, then an out-of-range select while the word drains.
        sel0 = 2'd1; vin0 = 3'b010; din0 = {16'h0000, 16'hA5A5, 16'h0000};
        step(0);
        sel0 = 2'd3;
        step(0);
        step(0);
        // Ready goes to the selected channel even though it is not valid.
        sel0 = 2'd2; vin0 = 3'b000;
        step(0);
        sel0 = 2'd0; vin0 = 3'b001; din0 = {16'h0000, 16'h0000, 16'h1234};
        step(0);
        vin0 = 3'b000;
        step(0);

        // MODE 1 round-robin with every channel valid, showing wrap-around.
        din1 = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        vin1 = 4'b1111;
        repeat (5) step(1);
        // Move the pointer to 2, then check the wrap past a non-valid channel.
        vin1 = 4'b0010;
        step(1);
        vin1 = 4'b1010;
        step(1);
        step(1);

        // Back-pressure: the held word stays put and no channel is granted.
        vin1 = 4'b1111; mr1 = 1'b0;
        repeat (3) step(1);
        // On release, the old word drains and a new one loads in the same cycle.
        mr1 = 1'b1;
        step(1);
        mr1 = 1'b0;
        step(1);

        // Asynchronous reset mid-cycle while a word is held.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_u1_m_out", 32'(mo1), 32'h0);
        chk("arst_u1_m_valid", 32'(mv1), 32'h0);
        chk("arst_u1_gid", 32'(gid1), 32'h0);
        chk("arst_u1_ready", 32'(rdy1), 32'h0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        mr1 = 1'b1;
        step(1);
        vin1 = 4'b0000;
        step(1);

        // MODE 0 with N_CH 2: back-to-back words with no bubble.
        din2 = {16'h2222, 16'h1111};
        sel2 = 1'b0; vin2 = 2'b01;
        step(2);
        sel2 = 1'b1; vin2 = 2'b10;
        step(2);
        sel2 = 1'b0; vin2 = 2'b01;
        step(2);
        vin2 = 2'b00;
        step(2);

        // MODE 0 with N_CH 16: the top channel passes through.
        for (int k = 0; k < 16; k++) begin
            din3[k*16 +: 16] = 16'hF000 + 16'(k);
        end
        sel3 = 4'd15; vin3 = 16'h8000;
        step(3);
        vin3 = 16'h0000;
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
